uart_tx: RTL and testbench

8N1 UART transmitter with a small input FIFO. It is the transmit half of the UART peripheral and the counterpart of `uart_rx`. It accepts bytes over a valid/ready handshake, buffers them, and serializes each one onto `o_tx` as start bit, 8 data bits LSB first, then stop bit. Queued bytes go out back-to-back with no idle gap between frames.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit FSM states and baud math.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic int bauds_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes ahead of the transmit serializer.
module uart_tx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered bytes are serialized LSB first, queued frames
// leave back-to-back with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int ClkFreq   = 10_000_000,
  parameter int BaudRate  = 115200,
  parameter int FifoDepth = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx,
  output logic       o_tx_busy
);

  localparam int BaudsPerBit = bauds_per_bit(ClkFreq, BaudRate);
  localparam int CntW        = (BaudsPerBit < 2) ? 1 : $clog2(BaudsPerBit);
  localparam int BitW        = $clog2(UART_DATA_BITS);
  localparam int FifoCntW    = $clog2(FifoDepth + 1);

  if (BaudsPerBit < 2) begin : g_bad_baud
    $error("uart_tx: ClkFreq/BaudRate must be at least 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FifoDepth must be a power of 2 and at least 2");
  end

  tx_state_t                 state_q, state_d;
  logic [CntW-1:0]           baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FifoCntW-1:0]       fifo_count;
  logic                      bit_last;

  assign o_tx_ready = !fifo_full;
  assign fifo_push  = i_tx_valid && o_tx_ready;
  assign o_tx       = tx_q;
  assign o_tx_busy  = (state_q != IDLE) || (fifo_count != '0);
  assign bit_last   = (baud_cnt_q == CntW'(BaudsPerBit - 1));

  uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (UART_DATA_BITS)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (fifo_push),
    .wdata   (i_tx_byte),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // o_tx is loaded one cycle ahead so each bit's level is registered at its boundary.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_last ? '0 : baud_cnt_q + CntW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_last) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_last) begin
          if (bit_idx_q == BitW'(UART_DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + BitW'(1);
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit with a loopback receiver
// model feeding a byte scoreboard.
module tb_uart_tx;

  localparam int ClkFreq   = 1_000_000;
  localparam int BaudRate  = 100_000;
  localparam int FifoDepth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_frames = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(
    .ClkFreq   (ClkFreq),
    .BaudRate  (BaudRate),
    .FifoDepth (FifoDepth)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_tx_valid (tx_valid),
    .i_tx_byte  (tx_byte),
    .o_tx_ready (tx_ready),
    .o_tx       (tx),
    .o_tx_busy  (tx_busy)
  );

  // Loopback receiver: samples the line mid-bit, 10 clocks per bit.
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_data = 8'h00;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 5) begin
        checks++;
        if (tx !== 1'b0) begin
          failures++;
          $display("FAIL rx_start_bit: line=%b required=0 at cycle %0d", tx, cyc);
          mon_active <= 1'b0;
        end
      end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
        mon_data[(mon_cnt - 15) / 10] <= tx;
      end else if (mon_cnt == 95) begin
        mon_active <= 1'b0;
        rx_frames++;
        checks++;
        if (tx !== 1'b1) begin
          failures++;
          $display("FAIL rx_stop_bit: line=%b required=1 at cycle %0d", tx, cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rx_unexpected_frame: got %02h, scoreboard empty", mon_data);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_data !== mon_exp) begin
            failures++;
            $display("FAIL rx_byte: got %02h required %02h", mon_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: tx=%b ready=%b busy=%b required 1 1 0", tx, tx_ready, tx_busy);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b required 1 1 0", tx, tx_ready, tx_busy);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    tx_valid = 1'b1;
    tx_byte  = 8'hA5;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready: ready=%b required 1", tx_ready);
    end
    sb.push_back(8'hA5);
    tick();
    tx_valid = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL single_early_start: tx=%b required 1 at accept edge", tx);
    end
    tick();
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (tx !== frame[k / 10]) begin
        failures++;
        $display("FAIL single_line[%0d]: tx=%b required %b", k, tx, frame[k / 10]);
      end
      if (k == 99) begin
        checks++;
        if (tx_busy !== 1'b1) begin
          failures++;
          $display("FAIL single_busy_last: busy=%b required 1", tx_busy);
        end
      end
      tick();
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_end: busy=%b required 0 after 100 cycles", tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] line;
    int base;
    line = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    base = rx_frames;
    tx_valid = 1'b1;
    tx_byte  = 8'h00;
    sb.push_back(8'h00);
    tick();
    tx_byte = 8'hFF;
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: ready=%b required 1", tx_ready);
    end
    sb.push_back(8'hFF);
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (tx !== line[k / 10]) begin
        failures++;
        $display("FAIL b2b_line[%0d]: tx=%b required %b", k, tx, line[k / 10]);
      end
      tick();
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_end: busy=%b required 0 after 200 cycles", tx_busy);
    end
    checks++;
    if (rx_frames - base !== 2) begin
      failures++;
      $display("FAIL b2b_frames: got %0d required 2", rx_frames - base);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [6];
    int base;
    int waited;
    int w;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    base = rx_frames;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_byte = bytes[i];
      checks++;
      if (tx_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_accept[%0d]: ready=%b required 1", i, tx_ready);
      end
      sb.push_back(bytes[i]);
      tick();
    end
    tx_byte = bytes[5];
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_low: ready=%b required 0", tx_ready);
    end
    waited = 0;
    while (!tx_ready && waited < 200) begin
      tick();
      waited++;
    end
    checks++;
    if (waited !== 97) begin
      failures++;
      $display("FAIL full_ready_rise: waited %0d cycles required 97", waited);
    end
    sb.push_back(bytes[5]);
    tick();
    tx_valid = 1'b0;
    w = 0;
    while ((tx_busy || sb.size() != 0) && w < 1000) begin
      tick();
      w++;
    end
    checks++;
    if (sb.size() != 0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL full_drain: pending=%0d busy=%b required 0 0", sb.size(), tx_busy);
    end
    checks++;
    if (rx_frames - base !== 6) begin
      failures++;
      $display("FAIL full_frames: got %0d required 6", rx_frames - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int bad;
    int w;
    base = rx_frames;
    tx_valid = 1'b1;
    tx_byte  = 8'h5A;
    sb.push_back(8'h5A);
    tick();
    tx_valid = 1'b0;
    tick();
    repeat (44) tick();
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_bit3: tx=%b busy=%b required 1 1", tx, tx_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: tx=%b ready=%b busy=%b required 1 1 0", tx, tx_ready, tx_busy);
    end
    tx_valid = 1'b1;
    tx_byte  = 8'hEE;
    repeat (3) tick();
    tx_valid = 1'b0;
    sb.delete();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_no_resume: %0d cycles active after release, required 0", bad);
    end
    tx_valid = 1'b1;
    tx_byte  = 8'h3C;
    sb.push_back(8'h3C);
    tick();
    tx_valid = 1'b0;
    tick();
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL midrst_new_start: tx=%b required 0", tx);
    end
    w = 0;
    while ((tx_busy || sb.size() != 0) && w < 300) begin
      tick();
      w++;
    end
    checks++;
    if (rx_frames - base !== 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL midrst_frames: got %0d frames pending %0d required 1 0", rx_frames - base, sb.size());
    end
  endtask

  task automatic test_random_loopback();
    int base;
    int gap;
    int w;
    int stalls;
    logic [7:0] b;
    base = rx_frames;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      b = 8'($urandom_range(0, 255));
      tx_valid = 1'b1;
      tx_byte  = b;
      w = 0;
      while (!tx_ready && w < 300) begin
        tick();
        w++;
      end
      if (w >= 300) stalls++;
      sb.push_back(b);
      tick();
      tx_valid = 1'b0;
    end
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL rand_ready_timeout: %0d stalls required 0", stalls);
    end
    w = 0;
    while ((tx_busy || sb.size() != 0) && w < 2000) begin
      tick();
      w++;
    end
    checks++;
    if (sb.size() != 0 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: pending=%0d busy=%b required 0 0", sb.size(), tx_busy);
    end
    checks++;
    if (rx_frames - base !== 256) begin
      failures++;
      $display("FAIL rand_frames: got %0d required 256", rx_frames - base);
    end
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_random_loopback();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
